// File: rtl/pipeline_control_unit_if.sv
// Control-unit bundle: Decode instruction and ALU flags in, stage selects/enables out.
// The datapath/hazard side holds the master modport; the control unit holds the slave.
interface pipeline_control_unit_if #(parameter int W = 32);
    logic [W-1:0] InstrD;
    logic [3:0]   ALUFlags;
    logic         FlushE;
    logic [1:0]   ImmSrcD;
    logic [1:0]   RegSrcD;
    logic         ALUSrcE;
    logic [1:0]   ALUControlE;
    logic         BranchTakenE;
    logic         MemWriteM;
    logic         RegWriteM;
    logic         RegWriteW;
    logic         MemtoRegW;
    logic         PCSrcW;
    logic         PCWrPendingF;

    modport master (
        output InstrD, ALUFlags, FlushE,
        input  ImmSrcD, RegSrcD, ALUSrcE, ALUControlE, BranchTakenE,
               MemWriteM, RegWriteM, RegWriteW, MemtoRegW, PCSrcW, PCWrPendingF
    );

    modport slave (
        input  InstrD, ALUFlags, FlushE,
        output ImmSrcD, RegSrcD, ALUSrcE, ALUControlE, BranchTakenE,
               MemWriteM, RegWriteM, RegWriteW, MemtoRegW, PCSrcW, PCWrPendingF
    );
endinterface

// File: rtl/pipeline_control_unit.sv
// Pipelined control: combinational decode in D; enables reach E/M/W after 1/2/3 cycles.
// No backpressure: never stalls; FlushE loads a never-execute bubble into the D/E register.
module pipeline_control_unit #(
    parameter int W = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    pipeline_control_unit_if.slave  bus
);

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    typedef struct packed {
        logic       regwrite;
        logic       memwrite;
        logic       memtoreg;
        logic       branch;
        logic       pcs;
        logic [1:0] flagwrite;
        logic       alusrc;
        logic [1:0] alucontrol;
        logic [3:0] cond;
    } de_t;

    localparam de_t DE_BUBBLE = '{regwrite: 1'b0, memwrite: 1'b0, memtoreg: 1'b0,
                                  branch: 1'b0, pcs: 1'b0, flagwrite: 2'b00,
                                  alusrc: 1'b0, alucontrol: 2'b00, cond: 4'b1111};

    logic [W-1:0] instr;
    logic [1:0]   op;
    logic [3:0]   cmd;
    logic         i_bit, s_bit, u_bit, l_bit;
    logic         unused_instr;

    assign instr        = bus.InstrD;
    assign op           = instr[27:26];
    assign i_bit        = instr[25];
    assign cmd          = instr[24:21];
    assign u_bit        = instr[23];
    assign s_bit        = instr[20];
    assign l_bit        = instr[20];
    assign unused_instr = ^{instr[19:16], instr[11:0]};

    de_t        dec;
    logic [1:0] immsrc_d;
    logic [1:0] regsrc_d;

    always_comb begin
        dec        = DE_BUBBLE;
        dec.cond   = instr[31:28];
        immsrc_d   = op;
        regsrc_d   = 2'b00;
        case (op)
            2'b00: begin
                dec.alusrc = i_bit;
                case (cmd)
                    4'b0100: begin dec.regwrite = 1'b1; dec.alucontrol = ALU_ADD; dec.flagwrite = {s_bit, s_bit}; end
                    4'b0010: begin dec.regwrite = 1'b1; dec.alucontrol = ALU_SUB; dec.flagwrite = {s_bit, s_bit}; end
                    4'b0000: begin dec.regwrite = 1'b1; dec.alucontrol = ALU_AND; dec.flagwrite = {s_bit, 1'b0}; end
                    4'b1100: begin dec.regwrite = 1'b1; dec.alucontrol = ALU_ORR; dec.flagwrite = {s_bit, 1'b0}; end
                    4'b1010: begin dec.alucontrol = ALU_SUB; dec.flagwrite = {s_bit, s_bit}; end
                    default: ;
                endcase
            end
            2'b01: begin
                dec.alusrc     = 1'b1;
                dec.alucontrol = u_bit ? ALU_ADD : ALU_SUB;
                if (l_bit) begin
                    dec.regwrite = 1'b1;
                    dec.memtoreg = 1'b1;
                end else begin
                    dec.memwrite = 1'b1;
                    regsrc_d[1]  = 1'b1;
                end
            end
            2'b10: begin
                dec.alusrc     = 1'b1;
                dec.alucontrol = ALU_ADD;
                dec.branch     = 1'b1;
                regsrc_d[0]    = 1'b1;
            end
            default: ;
        endcase
        dec.pcs = (instr[15:12] == 4'hF) & dec.regwrite & ~dec.branch;
    end

    de_t        de;
    logic [3:0] flags;
    logic       condex;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            de <= DE_BUBBLE;
        else if (bus.FlushE)
            de <= DE_BUBBLE;
        else
            de <= dec;
    end

    // flags = {N, Z, C, V}
    always_comb begin
        condex = 1'b0;
        case (de.cond)
            4'b0000: condex = flags[2];
            4'b0001: condex = ~flags[2];
            4'b0010: condex = flags[1];
            4'b0011: condex = ~flags[1];
            4'b0100: condex = flags[3];
            4'b0101: condex = ~flags[3];
            4'b0110: condex = flags[0];
            4'b0111: condex = ~flags[0];
            4'b1000: condex = flags[1] & ~flags[2];
            4'b1001: condex = ~flags[1] | flags[2];
            4'b1010: condex = (flags[3] == flags[0]);
            4'b1011: condex = (flags[3] != flags[0]);
            4'b1100: condex = ~flags[2] & (flags[3] == flags[0]);
            4'b1101: condex = flags[2] | (flags[3] != flags[0]);
            4'b1110: condex = 1'b1;
            default: condex = 1'b0;
        endcase
    end

    // Flush only bubbles the incoming instruction, so the one leaving E still updates flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags <= 4'b0000;
        end else begin
            if (de.flagwrite[1] & condex)
                flags[3:2] <= bus.ALUFlags[3:2];
            if (de.flagwrite[0] & condex)
                flags[1:0] <= bus.ALUFlags[1:0];
        end
    end

    logic regwrite_m, memwrite_m, memtoreg_m, pcs_m;
    logic regwrite_w, memtoreg_w, pcs_w;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regwrite_m <= 1'b0;
            memwrite_m <= 1'b0;
            memtoreg_m <= 1'b0;
            pcs_m      <= 1'b0;
            regwrite_w <= 1'b0;
            memtoreg_w <= 1'b0;
            pcs_w      <= 1'b0;
        end else begin
            regwrite_m <= de.regwrite & condex;
            memwrite_m <= de.memwrite & condex;
            memtoreg_m <= de.memtoreg;
            pcs_m      <= de.pcs & condex;
            regwrite_w <= regwrite_m;
            memtoreg_w <= memtoreg_m;
            pcs_w      <= pcs_m;
        end
    end

    assign bus.ImmSrcD      = immsrc_d;
    assign bus.RegSrcD      = regsrc_d;
    assign bus.ALUSrcE      = de.alusrc;
    assign bus.ALUControlE  = de.alucontrol;
    assign bus.BranchTakenE = de.branch & condex;
    assign bus.MemWriteM    = memwrite_m;
    assign bus.RegWriteM    = regwrite_m;
    assign bus.RegWriteW    = regwrite_w;
    assign bus.MemtoRegW    = memtoreg_w;
    assign bus.PCSrcW       = pcs_w;
    assign bus.PCWrPendingF = dec.pcs | (de.pcs & condex) | pcs_m;

endmodule

// File: doc/pipeline_control_unit.md
Name: pipeline_control_unit

Overview:
- Control path of the pipelined processor: decodes the Decode-stage instruction and drives the immediate extender's ImmSrc, register-source and ALU selects.
- Carries write enables through Execute/Memory/Writeback pipeline registers.
- Holds the NZCV flags register and evaluates ARM condition codes in Execute.
- Provides a flush hook and a PC-write-pending signal for the hazard unit.

Parameters:
W, 32, instruction width (fields below assume 32)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high; clears all registers
InstrD  input  W  Decode-stage instruction
ALUFlags  input  4  NZCV from the Execute-stage ALU
FlushE  input  1  load a bubble into the D/E control register
ImmSrcD  output  2  extender select: 00 = imm8 (data-processing), 01 = imm12 (memory), 10 = imm24 sign-extended (branch), 11 = undefined op (extender outputs 0)
RegSrcD  output  2  [0] = read R15 as Rn (branch), [1] = read Rd as Rm (STR)
ALUSrcE  output  1  1 = immediate operand
ALUControlE  output  2  00 ADD, 01 SUB, 10 AND, 11 ORR
BranchTakenE  output  1  conditional branch resolved taken
MemWriteM  output  1  data memory write enable
RegWriteM  output  1  for forwarding
RegWriteW  output  1  register file write enable
MemtoRegW  output  1  select read data
PCSrcW  output  1  R15 written by non-branch instruction
PCWrPendingF  output  1  PCS in D, E or M

Behaviour:
- Fields: Cond = [31:28], Op = [27:26], I = [25], Cmd = [24:21], S = [20], U = [23], L = [20], Rd = [15:12].
- Decode is combinational, so ImmSrcD and RegSrcD are valid in the same cycle as InstrD.
- Op = 00 (data-processing):
  - ImmSrc 00; ALUSrc = I.
  - Cmd decode: 0100 ADD→00, 0010 SUB→01, 0000 AND→10, 1100 ORR→11, 1010 CMP→01 with RegWrite = 0.
  - Any other Cmd decodes as a NOP: all enables 0.
  - RegWrite = 1 for all defined Cmd except CMP.
  - FlagWrite[1] (NZ) = S; FlagWrite[0] (CV) = S & (ADD | SUB | CMP).
- Op = 01 (memory):
  - ImmSrc 01; ALUSrc 1; ALUControl = U ? ADD : SUB.
  - L = 1 (LDR): RegWrite = 1, MemtoReg = 1.
  - L = 0 (STR): MemWrite = 1, RegSrc[1] = 1.
- Op = 10 (branch): ImmSrc 10; ALUSrc 1; ADD; Branch = 1; RegSrc[0] = 1. Bit 24 ignored (no link).
- Op = 11: ImmSrc 11; all enables 0.
- PCS = (Rd == 15 & RegWrite) & ~Branch.
- D/E register (RegWrite, MemWrite, MemtoReg, Branch, PCS, FlagWrite, ALUSrc, ALUControl, Cond):
  - Loads every cycle.
  - FlushE = 1 or reset loads all zeros, with Cond = 1111 (never).
- CondExE, combinational from CondE and the Flags register:
  - EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V.
  - HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V).
  - AL 1; 1111 → 0.
- Gating: RegWrite, MemWrite, PCS and FlagWrite are ANDed with CondExE before the E/M register. BranchTakenE = BranchE & CondExE.
- Flags (NZCV), reset 0000, updated at the clock edge:
  - NZ ← ALUFlags[3:2] if FlagWrite[1] & CondExE.
  - CV ← ALUFlags[1:0] if FlagWrite[0] & CondExE.
  - A flag write in E affects the condition check of the next instruction (one cycle later).
- E/M and M/W registers: plain one-cycle pipeline, no stall.
- Latency: D→E 1 cycle, →M 2 cycles, →W 3 cycles.
- PCWrPendingF = PCS_D | PCS_E (gated by CondExE) | PCS_M.
- Reset values: all registered outputs 0; Flags 0; PCWrPendingF 0 once InstrD decodes to a NOP.
- Simultaneous events:
  - FlushE with a flag-setting instruction in E: the flag update still occurs, because flush affects only the instruction entering E.
  - Reset asserted mid-operation clears every stage immediately (asynchronous); in-flight writes are lost.

Test Plan:
- ADD R1,R2,#5 (0xE2821005) → ImmSrcD = 00 immediately; ALUSrcE = 1 and ALUControlE = 00 next cycle; RegWriteW = 1 at cycle 3, MemtoRegW = 0.
- STR R3,[R4,#-8] (U = 0) → ImmSrcD = 01, RegSrcD = 10, ALUControlE = 01, MemWriteM = 1 at cycle 2, RegWriteW = 0. LDR → MemtoRegW = 1, RegWriteW = 1.
- SUBS with ALUFlags = 0100 (Z), then BEQ (0x0A000002) → BranchTakenE = 1. Same sequence with BNE → 0. BranchTakenE is never asserted by the SUBS itself.
- ADD R15,R0,R1 (AL) → PCWrPendingF high during its D, E and M cycles; PCSrcW = 1 at W. With cond NE and Z = 1 → PCSrcW = 0, RegWriteW = 0.
- FlushE asserted with LDR in D → that LDR produces no MemtoRegW or RegWriteW; the next instruction proceeds normally.
- Op = 11 instruction → ImmSrcD = 11, all enables 0. Asserting reset mid-pipeline → all outputs 0 and Flags 0000 without waiting for a clock edge.
